// File: rtl/vec_cache_req_alloc_arb_if.sv
// Request/MSHR-allocation/output bundle for vec_cache_req_alloc_arb.
// master drives requests, allocs and out_rdy; slave is the arbiter.
interface vec_cache_req_alloc_arb_if #(
  parameter int REQ_NUM         = 8,
  parameter int GRANT_NUM       = 2,
  parameter int PLD_WIDTH       = 64,
  parameter int ENTRY_IDX_WIDTH = 4
);
  localparam int SRC_W = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]                   req_vld;
  logic [REQ_NUM*PLD_WIDTH-1:0]         req_pld;
  logic [REQ_NUM-1:0]                   req_rdy;
  logic [GRANT_NUM-1:0]                 alloc_vld;
  logic [GRANT_NUM*ENTRY_IDX_WIDTH-1:0] alloc_idx;
  logic [GRANT_NUM-1:0]                 alloc_rdy;
  logic [GRANT_NUM-1:0]                 out_vld;
  logic [GRANT_NUM*PLD_WIDTH-1:0]       out_pld;
  logic [GRANT_NUM*ENTRY_IDX_WIDTH-1:0] out_idx;
  logic [GRANT_NUM*SRC_W-1:0]           out_src;
  logic [GRANT_NUM-1:0]                 out_rdy;
  logic [REQ_NUM-1:0]                   starve_flag;

  modport master (
    output req_vld, req_pld,
    output alloc_vld, alloc_idx,
    output out_rdy,
    input  req_rdy, alloc_rdy,
    input  out_vld, out_pld,
    input  out_idx, out_src,
    input  starve_flag
  );

  modport slave (
    input  req_vld, req_pld,
    input  alloc_vld, alloc_idx,
    input  out_rdy,
    output req_rdy, alloc_rdy,
    output out_vld, out_pld,
    output out_idx, out_src,
    output starve_flag
  );
endinterface

// File: rtl/vec_cache_req_alloc_arb.sv
// Multi-lane request-to-MSHR allocator with round-robin + starvation promotion.
// Ports: clk, rst (sync, active high), bus (slave modport: req/alloc/out).
module vec_cache_req_alloc_arb #(
  parameter int REQ_NUM         = 8,
  parameter int GRANT_NUM       = 2,
  parameter int PLD_WIDTH       = 64,
  parameter int ENTRY_IDX_WIDTH = 4,
  parameter int STARVE_LIMIT    = 15
) (
  input  logic clk,
  input  logic rst,
  vec_cache_req_alloc_arb_if.slave bus
);
  localparam int PW = $clog2(REQ_NUM);
  localparam int PX = PW + 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0]              rr_ptr;
  logic [CW-1:0]              cnt [REQ_NUM];
  logic [REQ_NUM-1:0]         starve;

  logic [PLD_WIDTH-1:0]       pld_arr [REQ_NUM];
  logic [ENTRY_IDX_WIDTH-1:0] idx_arr [GRANT_NUM];

  logic [GRANT_NUM-1:0]       lane_vld;
  logic [PLD_WIDTH-1:0]       lane_pld [GRANT_NUM];
  logic [ENTRY_IDX_WIDTH-1:0] lane_idx [GRANT_NUM];
  logic [PW-1:0]              lane_src [GRANT_NUM];

  logic [GRANT_NUM-1:0]       lane_open;
  logic [GRANT_NUM-1:0]       pick_lane;
  logic [PW-1:0]              pick_src [GRANT_NUM];
  logic [REQ_NUM-1:0]         pick_req;

  logic [PX-1:0]              cand;
  logic [PW-1:0]              ci;
  logic [PX-1:0]              max_pos;
  logic [PX-1:0]              nxt_sum;
  logic [PW-1:0]              nxt_ptr;
  logic                       any_gnt;
  logic                       want;
  logic                       taken;

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_req
    assign pld_arr[i] =
      bus.req_pld[i*PLD_WIDTH +: PLD_WIDTH];
  end

  for (genvar g = 0; g < GRANT_NUM; g++) begin : g_lane
    assign idx_arr[g] =
      bus.alloc_idx[g*ENTRY_IDX_WIDTH +: ENTRY_IDX_WIDTH];
    assign bus.out_pld[g*PLD_WIDTH +: PLD_WIDTH] =
      lane_pld[g];
    assign bus.out_idx[g*ENTRY_IDX_WIDTH +: ENTRY_IDX_WIDTH] =
      lane_idx[g];
    assign bus.out_src[g*PW +: PW] = lane_src[g];
  end

  assign bus.out_vld     = lane_vld;
  assign bus.req_rdy     = pick_req;
  assign bus.alloc_rdy   = pick_lane;
  assign bus.starve_flag = starve;

  // Two passes over the rotated requester order: promoted requesters
  // first, then the rest. Each winner takes the lowest still-free open
  // lane, so the k-th open lane gets the k-th candidate.
  always_comb begin
    lane_open = '0;
    if (!rst)
      lane_open = bus.alloc_vld & (~lane_vld | bus.out_rdy);
    pick_lane = '0;
    pick_req  = '0;
    for (int g = 0; g < GRANT_NUM; g++)
      pick_src[g] = '0;
    max_pos = '0;
    any_gnt = 1'b0;
    cand    = '0;
    ci      = '0;
    want    = 1'b0;
    taken   = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int p = 0; p < REQ_NUM; p++) begin
        cand = {1'b0, rr_ptr} + PX'(p);
        if (cand >= PX'(REQ_NUM))
          cand = cand - PX'(REQ_NUM);
        ci    = cand[PW-1:0];
        want  = bus.req_vld[ci] &&
                (starve[ci] == (pass == 0));
        taken = 1'b0;
        for (int g = 0; g < GRANT_NUM; g++) begin
          if (want && !taken &&
              lane_open[g] && !pick_lane[g]) begin
            pick_lane[g] = 1'b1;
            pick_src[g]  = ci;
            pick_req[ci] = 1'b1;
            taken        = 1'b1;
            any_gnt      = 1'b1;
            if (PX'(p) > max_pos)
              max_pos = PX'(p);
          end
        end
      end
    end
  end

  // Pointer moves past the granted requester furthest along the
  // round-robin order; a single conditional subtract keeps it in range
  // for non power-of-two REQ_NUM.
  always_comb begin
    nxt_sum = {1'b0, rr_ptr} + max_pos + PX'(1);
    if (nxt_sum >= PX'(REQ_NUM))
      nxt_sum = nxt_sum - PX'(REQ_NUM);
    nxt_ptr = nxt_sum[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      lane_vld <= '0;
      for (int g = 0; g < GRANT_NUM; g++) begin
        lane_pld[g] <= '0;
        lane_idx[g] <= '0;
        lane_src[g] <= '0;
      end
    end else begin
      if (any_gnt)
        rr_ptr <= nxt_ptr;
      for (int g = 0; g < GRANT_NUM; g++) begin
        if (pick_lane[g]) begin
          lane_vld[g] <= 1'b1;
          lane_pld[g] <= pld_arr[pick_src[g]];
          lane_idx[g] <= idx_arr[g];
          lane_src[g] <= pick_src[g];
        end else if (bus.out_rdy[g]) begin
          lane_vld[g] <= 1'b0;
        end
      end
    end
  end

  // starve mirrors (next counter == limit) so the flag and counter
  // change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
      for (int i = 0; i < REQ_NUM; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (!bus.req_vld[i] || pick_req[i]) begin
          cnt[i]    <= '0;
          starve[i] <= 1'b0;
        end else if (cnt[i] != CW'(STARVE_LIMIT)) begin
          cnt[i]    <= cnt[i] + CW'(1);
          starve[i] <= (cnt[i] == CW'(STARVE_LIMIT - 1));
        end
      end
    end
  end
endmodule

// File: tb/tb_vec_cache_req_alloc_arb.sv
// Self-checking bench for vec_cache_req_alloc_arb (8x2 and 5x3 configs).
// Expected lane contents are queued at drive time, popped after each edge.
module tb_vec_cache_req_alloc_arb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_cache_req_alloc_arb_if #(
    .REQ_NUM(8), .GRANT_NUM(2),
    .PLD_WIDTH(64), .ENTRY_IDX_WIDTH(4)
  ) bus0 ();

  vec_cache_req_alloc_arb_if #(
    .REQ_NUM(5), .GRANT_NUM(3),
    .PLD_WIDTH(16), .ENTRY_IDX_WIDTH(4)
  ) bus1 ();

  vec_cache_req_alloc_arb u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  vec_cache_req_alloc_arb #(
    .REQ_NUM(5), .GRANT_NUM(3),
    .PLD_WIDTH(16), .ENTRY_IDX_WIDTH(4),
    .STARVE_LIMIT(15)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    int          dut;
    int          lane;
    logic [63:0] pld;
    logic [7:0]  idx;
    logic [7:0]  src;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [63:0] hold_pld;
  logic [7:0]  m;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pld0(int i, int c);
    return 64'hA500_0000_0000_0000 +
           (64'(c) << 16) + 64'(i);
  endfunction

  function automatic logic [15:0] pld1(int i, int c);
    logic [15:0] r;
    r = {8'(c), 8'(i)};
    return r;
  endfunction

  task automatic drive0(input logic [7:0] v,
                        input logic [1:0] av,
                        input logic [7:0] ai,
                        input logic [1:0] ordy);
    bus0.req_vld   = v;
    bus0.alloc_vld = av;
    bus0.alloc_idx = ai;
    bus0.out_rdy   = ordy;
    for (int i = 0; i < 8; i++)
      bus0.req_pld[i*64 +: 64] = pld0(i, cyc);
  endtask

  task automatic drive1(input logic [4:0] v,
                        input logic [2:0] av,
                        input logic [11:0] ai,
                        input logic [2:0] ordy);
    bus1.req_vld   = v;
    bus1.alloc_vld = av;
    bus1.alloc_idx = ai;
    bus1.out_rdy   = ordy;
    for (int i = 0; i < 5; i++)
      bus1.req_pld[i*16 +: 16] = pld1(i, cyc);
  endtask

  task automatic push(input int d, input int g,
                      input int src, input int idx);
    exp_t e;
    e.dut  = d;
    e.lane = g;
    e.src  = 8'(src);
    e.idx  = 8'(idx);
    if (d == 0) e.pld = pld0(src, cyc);
    else        e.pld = 64'(pld1(src, cyc));
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        chk("d0_vld", 64'(bus0.out_vld[e.lane]), 64'd1);
        chk("d0_src",
            64'(bus0.out_src[e.lane*3 +: 3]), 64'(e.src));
        chk("d0_idx",
            64'(bus0.out_idx[e.lane*4 +: 4]), 64'(e.idx));
        chk("d0_pld",
            bus0.out_pld[e.lane*64 +: 64], e.pld);
      end else begin
        chk("d1_vld", 64'(bus1.out_vld[e.lane]), 64'd1);
        chk("d1_src",
            64'(bus1.out_src[e.lane*3 +: 3]), 64'(e.src));
        chk("d1_idx",
            64'(bus1.out_idx[e.lane*4 +: 4]), 64'(e.idx));
        chk("d1_pld",
            64'(bus1.out_pld[e.lane*16 +: 16]), e.pld);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive0(8'h00, 2'b00, 8'h00, 2'b00);
    drive1(5'h00, 3'b000, 12'h000, 3'b000);
    tick();
    tick();
    chk("rst_vld",    64'(bus0.out_vld), 64'd0);
    chk("rst_pld",    bus0.out_pld[63:0], 64'd0);
    chk("rst_src",    64'(bus0.out_src), 64'd0);
    chk("rst_idx",    64'(bus0.out_idx), 64'd0);
    chk("rst_starve", 64'(bus0.starve_flag), 64'd0);
    chk("rst_vld1",   64'(bus1.out_vld), 64'd0);

    // requests and open lanes during reset: no handshake
    drive0(8'hFF, 2'b11, 8'h53, 2'b11);
    drive1(5'h1F, 3'b111, 12'h654, 3'b111);
    #1;
    chk("rst_req_rdy",   64'(bus0.req_rdy), 64'd0);
    chk("rst_alloc_rdy", 64'(bus0.alloc_rdy), 64'd0);
    chk("rst_req_rdy1",  64'(bus1.req_rdy), 64'd0);
    tick();
    chk("rst_hold_vld", 64'(bus0.out_vld), 64'd0);
    rst = 1'b0;
    drive1(5'h00, 3'b000, 12'h654, 3'b111);

    // full rotation, two grants per cycle
    for (int c = 0; c < 8; c++) begin
      drive0(8'hFF, 2'b11, 8'h53, 2'b11);
      #1;
      m = 8'(1 << ((2*c) % 8)) |
          8'(1 << ((2*c+1) % 8));
      chk("rot_req_rdy",   64'(bus0.req_rdy), 64'(m));
      chk("rot_alloc_rdy", 64'(bus0.alloc_rdy), 64'd3);
      push(0, 0, (2*c) % 8, 3);
      push(0, 1, (2*c+1) % 8, 5);
      tick();
    end

    // only lane1 offered, single requester
    drive0(8'h01, 2'b10, 8'h53, 2'b11);
    #1;
    chk("l1_req_rdy",   64'(bus0.req_rdy), 64'h01);
    chk("l1_alloc_rdy", 64'(bus0.alloc_rdy), 64'd2);
    push(0, 1, 0, 5);
    tick();
    chk("l1_lane0_vld", 64'(bus0.out_vld[0]), 64'd0);

    // fill lane0, then stall it while lane1 streams
    drive0(8'hFF, 2'b11, 8'h53, 2'b11);
    #1;
    chk("fill_req_rdy", 64'(bus0.req_rdy), 64'h06);
    push(0, 0, 1, 3);
    push(0, 1, 2, 5);
    hold_pld = pld0(1, cyc);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive0(8'hFF, 2'b11, 8'h97, 2'b10);
      #1;
      chk("stall_req_rdy",
          64'(bus0.req_rdy), 64'(8'(1 << (3+k))));
      chk("stall_alloc_rdy", 64'(bus0.alloc_rdy), 64'd2);
      push(0, 1, 3+k, 9);
      tick();
      chk("hold_vld", 64'(bus0.out_vld[0]), 64'd1);
      chk("hold_src", 64'(bus0.out_src[2:0]), 64'd1);
      chk("hold_idx", 64'(bus0.out_idx[3:0]), 64'd3);
      chk("hold_pld", bus0.out_pld[63:0], hold_pld);
    end
    drive0(8'h00, 2'b00, 8'h53, 2'b11);
    tick();
    chk("drain_vld", 64'(bus0.out_vld), 64'd0);

    // requester 7 waits with no lane open
    for (int w = 1; w <= 17; w++) begin
      drive0(8'h80, 2'b00, 8'h53, 2'b11);
      #1;
      chk("closed_req_rdy", 64'(bus0.req_rdy), 64'd0);
      tick();
      if (w == 14)
        chk("starve_pre", 64'(bus0.starve_flag), 64'h00);
      if (w == 15)
        chk("starve_set", 64'(bus0.starve_flag), 64'h80);
      if (w == 17)
        chk("starve_sat", 64'(bus0.starve_flag), 64'h80);
    end
    // rr_ptr is 6 here: promotion must let 7 beat 6
    drive0(8'hC0, 2'b01, 8'h53, 2'b11);
    #1;
    chk("promo_req_rdy",   64'(bus0.req_rdy), 64'h80);
    chk("promo_alloc_rdy", 64'(bus0.alloc_rdy), 64'd1);
    push(0, 0, 7, 3);
    tick();
    chk("starve_clr", 64'(bus0.starve_flag), 64'h00);

    // reset with both lanes full and stalled
    drive0(8'hFF, 2'b11, 8'h53, 2'b11);
    #1;
    chk("pre_rst_req_rdy", 64'(bus0.req_rdy), 64'h03);
    push(0, 0, 0, 3);
    push(0, 1, 1, 5);
    tick();
    rst = 1'b1;
    drive0(8'hFF, 2'b11, 8'h53, 2'b00);
    #1;
    chk("rst2_req_rdy",   64'(bus0.req_rdy), 64'd0);
    chk("rst2_alloc_rdy", 64'(bus0.alloc_rdy), 64'd0);
    tick();
    chk("rst2_vld", 64'(bus0.out_vld), 64'd0);
    chk("rst2_src", 64'(bus0.out_src), 64'd0);
    chk("rst2_pld", bus0.out_pld[127:64], 64'd0);
    rst = 1'b0;
    drive0(8'hFF, 2'b11, 8'h53, 2'b11);
    #1;
    chk("post_rst_req_rdy", 64'(bus0.req_rdy), 64'h03);
    push(0, 0, 0, 3);
    push(0, 1, 1, 5);
    tick();
    drive0(8'h00, 2'b00, 8'h53, 2'b11);

    // 5 requesters, 3 lanes: non power-of-two wrap
    for (int c = 0; c < 6; c++) begin
      int p;
      logic [4:0] m5;
      p  = (3*c) % 5;
      m5 = '0;
      for (int g = 0; g < 3; g++)
        m5[(p+g) % 5] = 1'b1;
      drive1(5'h1F, 3'b111, 12'h654, 3'b111);
      #1;
      chk("w5_req_rdy",   64'(bus1.req_rdy), 64'(m5));
      chk("w5_alloc_rdy", 64'(bus1.alloc_rdy), 64'd7);
      for (int g = 0; g < 3; g++)
        push(1, g, (p+g) % 5, 4+g);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vec_cache_req_alloc_arb.md
VEC_CACHE_REQ_ALLOC_ARB -- requirements
Module: vec_cache_req_alloc_arb

Interface
REQ-001 SHALL have parameter REQ_NUM, default 8, number of request ports (2..32).
REQ-002 SHALL have parameter GRANT_NUM, default 2, number of grant lanes (1..REQ_NUM).
REQ-003 SHALL have parameter PLD_WIDTH, default 64, request payload bits.
REQ-004 SHALL have parameter ENTRY_IDX_WIDTH, default 4, MSHR entry index bits.
REQ-005 SHALL have parameter STARVE_LIMIT, default 15, wait cycles before a requester is promoted (1..255).
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port req_vld  input  REQ_NUM  per-requester valid.
REQ-009 SHALL have port req_pld  input  REQ_NUM*PLD_WIDTH  payloads; requester i occupies bits [i*PLD_WIDTH +: PLD_WIDTH].
REQ-010 SHALL have port req_rdy  output  REQ_NUM  per-requester accept.
REQ-011 SHALL have port alloc_vld  input  GRANT_NUM  MSHR slot available for lane g.
REQ-012 SHALL have port alloc_idx  input  GRANT_NUM*ENTRY_IDX_WIDTH  MSHR entry index offered to lane g.
REQ-013 SHALL have port alloc_rdy  output  GRANT_NUM  MSHR slot consumed by lane g this cycle.
REQ-014 SHALL have port out_vld  output  GRANT_NUM  registered lane valid.
REQ-015 SHALL have port out_pld  output  GRANT_NUM*PLD_WIDTH  registered payload.
REQ-016 SHALL have port out_idx  output  GRANT_NUM*ENTRY_IDX_WIDTH  registered MSHR index (rob entry).
REQ-017 SHALL have port out_src  output  GRANT_NUM*$clog2(REQ_NUM)  registered source requester id.
REQ-018 SHALL have port out_rdy  input  GRANT_NUM  independent per-lane downstream ready.
REQ-019 SHALL have port starve_flag  output  REQ_NUM  registered; bit i high while requester i counter equals STARVE_LIMIT.

Function
REQ-020 Lane g SHALL be open in a cycle iff alloc_vld[g] && (!out_vld[g] || out_rdy[g]).
REQ-021 Candidate order SHALL be: promoted requesters (starve_flag=1) first, then the rest; within each group round-robin order starting at rr_ptr, wrapping modulo REQ_NUM.
REQ-022 The k-th open lane (ascending g) SHALL be assigned the k-th valid candidate; no requester SHALL be assigned to more than one lane per cycle.
REQ-023 req_rdy[i] and alloc_rdy[g] SHALL be combinational and high exactly for assigned requesters/lanes; a handshake occurs only with req_vld[i] high.
REQ-024 An assigned lane SHALL load out_pld, out_idx (from alloc_idx[g]), out_src and set out_vld on the next edge; latency request-to-out_vld = 1 cycle.
REQ-025 An open lane with no assignment SHALL clear out_vld if out_rdy[g] was high, else hold.
REQ-026 While out_vld[g] && !out_rdy[g], lane g outputs SHALL hold stable.
REQ-027 Drain and refill in the same cycle SHALL be supported: full throughput of one grant per lane per cycle.
REQ-028 rr_ptr SHALL advance to (highest-order granted requester in round-robin order + 1) mod REQ_NUM when any grant occurs; unchanged otherwise.
REQ-029 Starvation counter i SHALL increment (saturating at STARVE_LIMIT) each cycle req_vld[i] && !req_rdy[i], clear on handshake, clear when req_vld[i] low.
REQ-030 Fewer candidates than open lanes: lowest open lanes filled; remaining lanes SHALL not assert alloc_rdy.
REQ-031 No open lane: all req_rdy and alloc_rdy SHALL be 0; counters keep counting.
REQ-032 REQ_NUM not a power of two SHALL wrap correctly (no out-of-range rr_ptr).

Reset
REQ-033 On rst=1 at an edge: out_vld=0, rr_ptr=0, all counters and starve_flag=0; out_pld/out_idx/out_src SHALL be 0.
REQ-034 During rst=1, req_rdy and alloc_rdy SHALL be 0; lane contents are dropped without handshake.
REQ-035 First cycle after rst deasserts SHALL arbitrate normally from rr_ptr=0.

Verification
REQ-036 Defaults, req_vld=8'hFF, alloc_vld=2'b11, alloc_idx={4'd5,4'd3}, out_rdy=2'b11 -> cycle0 req_rdy=8'h03; next cycle out_src={1,0}, out_idx={5,3}; then req_rdy=8'h0C, rotation 0..7 repeats.
REQ-037 alloc_vld=2'b10 only, req_vld=8'h01 -> lane1 gets requester 0, alloc_rdy=2'b10, lane0 out_vld stays 0.
REQ-038 out_rdy[0]=0 with lane0 full, out_rdy[1]=1 -> lane0 pld/idx/src stable, lane1 accepts one request per cycle.
REQ-039 Requester 7 valid while 0..6 continuously win (GRANT_NUM=1, constant rr hazard forced via req toggling) -> starve_flag[7] after 15 waiting cycles, granted next open cycle, counter cleared.
REQ-040 Assert rst with both lanes full and out_rdy=0 -> next cycle out_vld=0, rr_ptr=0, no alloc_rdy during reset.
REQ-041 REQ_NUM=5, GRANT_NUM=3, all valid -> grants {0,1,2},{3,4,0},{1,2,3}... with correct wrap.
